// File: rtl/fifo_byte_serializer_pkg.sv
// Shared definitions for the FIFO-to-serial converter: FSM state encoding and default word width.
package serializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t REQ   = 2'd1;
    localparam state_t WAIT  = 2'd2;
    localparam state_t SHIFT = 2'd3;

endpackage

// File: rtl/fifo_byte_serializer_if.sv
// Bundles the upstream FIFO read port and the downstream serial valid/ready stream.
interface fifo_byte_serializer_if #(
    parameter int WIDTH = serializer_pkg::DEFAULT_WIDTH
);
    logic             enable;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_read_en;
    logic             sout_ready;
    logic             sout;
    logic             sout_valid;
    logic             sout_first;
    logic             sout_last;
    logic             busy;

    modport master (
        output enable, fifo_empty, fifo_data, sout_ready,
        input  fifo_read_en, sout, sout_valid, sout_first, sout_last, busy
    );

    modport slave (
        input  enable, fifo_empty, fifo_data, sout_ready,
        output fifo_read_en, sout, sout_valid, sout_first, sout_last, busy
    );
endinterface

// File: rtl/fifo_byte_serializer_piso_shift_reg.sv
// Parallel-in serial-out register; o_bit always presents the next bit in the chosen order.
module piso_shift_reg
    import serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_shift,
    output logic             o_bit
);

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_shifted;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shifted = {r_data[WIDTH-2:0], 1'b0};
            assign o_bit     = r_data[WIDTH-1];
        end else begin : g_lsb_first
            assign w_shifted = {1'b0, r_data[WIDTH-1:1]};
            assign o_bit     = r_data[0];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end else if (i_shift) begin
            r_data <= w_shifted;
        end
    end

endmodule

// File: rtl/fifo_byte_serializer.sv
// Pulls one word at a time from an upstream FIFO and streams it out bit-serially
// under valid/ready flow control; the FSM and bit counter live here, the shifter below.
module fifo_byte_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    fifo_byte_serializer_if.slave  bus
);

    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             w_start;
    logic             w_accept;
    logic             w_last_accept;
    logic             w_load;
    logic             w_bit;

    assign w_start       = bus.enable && !bus.fifo_empty;
    assign w_accept      = (r_state == SHIFT) && bus.sout_ready;
    assign w_last_accept = w_accept && (r_bit_cnt == LAST_CNT);
    // FIFO data is valid the cycle after the read strobe, i.e. during WAIT.
    assign w_load        = (r_state == WAIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_next = REQ;
            REQ:     w_state_next = WAIT;
            WAIT:    w_state_next = SHIFT;
            SHIFT:   if (w_last_accept) w_state_next = w_start ? REQ : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.fifo_read_en = 1'b0;
        bus.busy         = 1'b0;
        bus.sout_valid   = 1'b0;
        bus.sout         = 1'b0;
        bus.sout_first   = 1'b0;
        bus.sout_last    = 1'b0;
        case (r_state)
            REQ: begin
                bus.fifo_read_en = 1'b1;
                bus.busy         = 1'b1;
            end
            WAIT: begin
                bus.busy = 1'b1;
            end
            SHIFT: begin
                bus.busy       = 1'b1;
                bus.sout_valid = 1'b1;
                bus.sout       = w_bit;
                bus.sout_first = (r_bit_cnt == '0);
                bus.sout_last  = (r_bit_cnt == LAST_CNT);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt <= '0;
        end else if (w_load) begin
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            r_bit_cnt <= w_last_accept ? '0 : r_bit_cnt + CNT_W'(1);
        end
    end

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_load),
        .i_data  (bus.fifo_data),
        .i_shift (w_accept),
        .o_bit   (w_bit)
    );

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Directed bench: an MSB-first instance fed by a small FIFO model, plus an LSB-first instance.
module tb_fifo_byte_serializer;
    import serializer_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fifo_byte_serializer_if #(.WIDTH(8)) bus0 ();
    fifo_byte_serializer_if #(.WIDTH(8)) bus1 ();

    fifo_byte_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    fifo_byte_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    // Upstream FIFO model for dut0: data appears the cycle after the read strobe.
    logic [7:0] fifo_mem [16];
    int wr_ptr  = 0;
    int rd_ptr  = 0;
    int bad_pop = 0;

    assign bus0.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (bus0.fifo_read_en) begin
            if (wr_ptr == rd_ptr) begin
                bad_pop <= bad_pop + 1;
            end else begin
                bus0.fifo_data <= fifo_mem[rd_ptr % 16];
                rd_ptr         <= rd_ptr + 1;
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        fifo_mem[wr_ptr % 16] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    function automatic logic [5:0] obs0();
        return {bus0.fifo_read_en, bus0.busy, bus0.sout_valid, bus0.sout, bus0.sout_first, bus0.sout_last};
    endfunction

    function automatic logic [5:0] obs1();
        return {bus1.fifo_read_en, bus1.busy, bus1.sout_valid, bus1.sout, bus1.sout_first, bus1.sout_last};
    endfunction

    // Per-cycle trace of dut0 for the multi-cycle scenarios.
    logic tr_v [64], tr_s [64], tr_f [64], tr_l [64], tr_r [64], tr_b [64], tr_rdy [64];

    task automatic capture(input int n, input bit toggle, input int drop_at);
        bit tog  = 1'b0;
        int nacc = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (toggle && bus0.sout_valid) begin
                bus0.sout_ready = tog;
                tog = !tog;
            end else begin
                bus0.sout_ready = 1'b1;
            end
            #1;
            tr_v[c]   = bus0.sout_valid;
            tr_s[c]   = bus0.sout;
            tr_f[c]   = bus0.sout_first;
            tr_l[c]   = bus0.sout_last;
            tr_r[c]   = bus0.fifo_read_en;
            tr_b[c]   = bus0.busy;
            tr_rdy[c] = bus0.sout_ready;
            if (tr_v[c] && tr_rdy[c]) nacc++;
            if (drop_at > 0 && nacc == drop_at) bus0.enable = 1'b0;
        end
    endtask

    task automatic analyze(input int n, output int nv, output int nr, output logic [31:0] bits,
                           output int gap, output int holderr, output int nlast, output logic final_busy);
        bit seen = 1'b0;
        int run  = 0;
        nv = 0; nr = 0; bits = '0; gap = 0; holderr = 0; nlast = 0;
        for (int c = 0; c < n; c++) begin
            if (tr_v[c]) nv++;
            if (tr_r[c]) nr++;
            if (tr_v[c] && tr_rdy[c]) bits = {bits[30:0], tr_s[c]};
            if (tr_v[c] && tr_rdy[c] && tr_l[c]) nlast++;
            if (c > 0 && tr_v[c-1] && !tr_rdy[c-1] &&
                (!tr_v[c] || tr_s[c] !== tr_s[c-1] || tr_f[c] !== tr_f[c-1] || tr_l[c] !== tr_l[c-1]))
                holderr++;
            if (tr_v[c]) begin
                if (seen && run > 0) gap = run;
                run  = 0;
                seen = 1'b1;
            end else if (seen) begin
                run++;
            end
        end
        final_busy = tr_b[n-1];
    endtask

    typedef struct {
        logic       en;
        logic       rdy;
        logic [5:0] exp;   // {read_en, busy, valid, sout, first, last}
    } vec_t;

    vec_t vecs [11];

    initial begin
        int          nv, nr, gap, holderr, nlast, nacc, n1v, n1r;
        logic [31:0] bits;
        logic        fbusy, first_ok;
        logic [7:0]  bits1;

        vecs[0]  = '{1'b1, 1'b1, 6'b110000};
        vecs[1]  = '{1'b1, 1'b1, 6'b010000};
        vecs[2]  = '{1'b1, 1'b1, 6'b011110};
        vecs[3]  = '{1'b1, 1'b1, 6'b011000};
        vecs[4]  = '{1'b1, 1'b1, 6'b011100};
        vecs[5]  = '{1'b1, 1'b1, 6'b011000};
        vecs[6]  = '{1'b1, 1'b1, 6'b011000};
        vecs[7]  = '{1'b1, 1'b1, 6'b011100};
        vecs[8]  = '{1'b1, 1'b1, 6'b011000};
        vecs[9]  = '{1'b1, 1'b1, 6'b011101};
        vecs[10] = '{1'b1, 1'b1, 6'b000000};

        reset_n         = 1'b0;
        bus0.enable     = 1'b0;
        bus0.sout_ready = 1'b1;
        bus1.enable     = 1'b0;
        bus1.fifo_empty = 1'b1;
        bus1.fifo_data  = 8'h01;
        bus1.sout_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs_dut0", 32'(obs0()), 32'h0);
        check("reset_outputs_dut1", 32'(obs1()), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 32'(obs0()), 32'h0);

        // Single word A5, MSB first, table of per-cycle outputs.
        push(8'hA5);
        for (int i = 0; i < 11; i++) begin
            bus0.enable     = vecs[i].en;
            bus0.sout_ready = vecs[i].rdy;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("a5_cycle%0d", i), 32'(obs0()), 32'(vecs[i].exp));
        end
        bus0.enable = 1'b0;
        $display("transaction: word A5 streamed");

        // Two queued words back to back.
        push(8'h3C);
        push(8'hC3);
        bus0.enable = 1'b1;
        capture(30, 1'b0, 0);
        bus0.enable = 1'b0;
        analyze(30, nv, nr, bits, gap, holderr, nlast, fbusy);
        check("two_words_read_pulses", 32'(nr), 32'd2);
        check("two_words_bits", bits, 32'h0000_3CC3);
        check("two_words_valid_cycles", 32'(nv), 32'd16);
        check("two_words_gap", 32'(gap), 32'd2);
        check("two_words_idle_at_end", 32'(fbusy), 32'd0);
        $display("transaction: words 3C C3 streamed");

        // F0 with ready toggling while valid.
        push(8'hF0);
        bus0.enable = 1'b1;
        capture(30, 1'b1, 0);
        bus0.enable     = 1'b0;
        bus0.sout_ready = 1'b1;
        analyze(30, nv, nr, bits, gap, holderr, nlast, fbusy);
        check("toggle_valid_cycles", 32'(nv), 32'd16);
        check("toggle_bits", bits, 32'h0000_00F0);
        check("toggle_hold_errors", 32'(holderr), 32'd0);
        check("toggle_read_pulses", 32'(nr), 32'd1);
        check("toggle_last_count", 32'(nlast), 32'd1);
        $display("transaction: word F0 streamed with backpressure");

        // Reset after bit 3 of FF.
        push(8'hFF);
        bus0.enable = 1'b1;
        nacc = 0;
        for (int c = 0; c < 20 && nacc < 3; c++) begin
            @(negedge clk);
            if (bus0.sout_valid && bus0.sout_ready) nacc++;
        end
        check("reset_reached_bit3", 32'(nacc), 32'd3);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("reset_mid_word_outputs", 32'(obs0()), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        nr = 0;
        nv = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus0.fifo_read_en) nr++;
            if (bus0.busy) nv++;
        end
        check("post_reset_no_read", 32'(nr), 32'd0);
        check("post_reset_busy_cycles", 32'(nv), 32'd0);
        bus0.enable = 1'b0;
        $display("transaction: reset during word FF");

        // Enable dropped during bit 4 with a second word queued.
        push(8'h55);
        push(8'hAA);
        bus0.enable = 1'b1;
        capture(30, 1'b0, 4);
        bus0.enable = 1'b0;
        analyze(30, nv, nr, bits, gap, holderr, nlast, fbusy);
        check("drop_enable_read_pulses", 32'(nr), 32'd1);
        check("drop_enable_bits", bits, 32'h0000_0055);
        check("drop_enable_idle", 32'(fbusy), 32'd0);
        check("drop_enable_fifo_left", 32'(wr_ptr - rd_ptr), 32'd1);
        $display("transaction: word 55 streamed, enable dropped");

        // LSB-first instance with 01.
        bus1.fifo_empty = 1'b0;
        bus1.enable     = 1'b1;
        bits1    = '0;
        n1v      = 0;
        n1r      = 0;
        first_ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus1.fifo_read_en) begin
                n1r++;
                bus1.enable = 1'b0;
            end
            if (bus1.sout_valid) begin
                bits1 = {bits1[6:0], bus1.sout};
                n1v++;
                if (n1v == 1) first_ok = bus1.sout_first;
            end
        end
        check("lsb_first_bits", 32'(bits1), 32'h0000_0080);
        check("lsb_first_valid_cycles", 32'(n1v), 32'd8);
        check("lsb_first_read_pulses", 32'(n1r), 32'd1);
        check("lsb_first_first_flag", 32'(first_ok), 32'd1);
        $display("transaction: word 01 streamed LSB first");

        check("no_read_while_empty", 32'(bad_pop), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_byte_serializer.md
FIFO_BYTE_SERIALIZER -- requirements
Module: fifo_byte_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning FIFO word width in bits.
REQ-002 SHALL have parameter MSB_FIRST, default 1, where 1 shifts bit WIDTH-1 first and 0 shifts bit 0 first.
REQ-003 SHALL have port clk  input  1  single clock; all state on the rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  permits starting a new byte.
REQ-006 SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-007 SHALL have port fifo_data  input  WIDTH  upstream FIFO read data, valid the cycle after fifo_read_en.
REQ-008 SHALL have port fifo_read_en  output  1  one-cycle read strobe to the FIFO.
REQ-009 SHALL have port sout_ready  input  1  downstream accepts the current bit.
REQ-010 SHALL have port sout  output  1  serial data bit.
REQ-011 SHALL have port sout_valid  output  1  sout holds a valid bit.
REQ-012 SHALL have port sout_first  output  1  current bit is bit 1 of a word.
REQ-013 SHALL have port sout_last  output  1  current bit is bit WIDTH of a word.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement the states IDLE, REQ, WAIT and SHIFT.
REQ-016 SHALL go IDLE->REQ when enable=1 and fifo_empty=0; otherwise it SHALL stay in IDLE.
REQ-017 SHALL drive fifo_read_en=1 only in REQ, as a Moore output lasting exactly one cycle, and SHALL then go REQ->WAIT unconditionally.
REQ-018 SHALL load fifo_data into the shift register at the end of WAIT and go WAIT->SHIFT.
REQ-019 SHALL drive sout_valid=1 in SHIFT; sout SHALL be the current bit in the MSB_FIRST order.
REQ-020 SHALL advance one bit per cycle in which sout_valid and sout_ready are both 1; with sout_ready=0, sout and the flags SHALL hold.
REQ-021 SHALL use a bit counter of width clog2(WIDTH) that runs from 0 to WIDTH-1; sout_first SHALL be high when the count is 0 and sout_last when it is WIDTH-1.
REQ-022 SHALL, when the last bit is accepted, go SHIFT->REQ if enable=1 and fifo_empty=0, otherwise go SHIFT->IDLE; back-to-back words therefore have a 2-cycle gap.
REQ-023 SHALL finish the current word if enable drops during REQ, WAIT or SHIFT; enable SHALL gate only new starts.
REQ-024 SHALL ignore fifo_empty outside IDLE and the last-bit decision, and SHALL never assert fifo_read_en while fifo_empty=1 was sampled.
REQ-025 SHALL drive sout=0 when sout_valid=0.

Reset
REQ-026 SHALL, when reset_n=0, immediately force state IDLE, counter 0, shift register 0, and fifo_read_en, sout, sout_valid, sout_first, sout_last and busy all to 0.
REQ-027 SHALL discard any partially shifted word on reset mid-operation, and SHALL NOT issue any read until reset_n=1 and the IDLE start conditions are met.

Structure
REQ-028 SHALL take the state encoding (2-bit localparams IDLE=0, REQ=1, WAIT=2, SHIFT=3) and the default WIDTH from a shared package, serializer_pkg.
REQ-029 SHALL contain one sub-module, piso_shift_reg (parallel load, shift-enable, MSB_FIRST parameter); the FSM and counter SHALL stay in the top module.

Verification
REQ-030 The bench SHALL cover: single word 8'hA5, sout_ready=1, MSB_FIRST=1 -> read_en pulse, then sout 1,0,1,0,0,1,0,1 on 8 consecutive cycles, first on bit 1, last on bit 8, then IDLE.
REQ-031 The bench SHALL cover: two words 8'h3C and 8'hC3 queued -> exactly 2 read_en pulses, a 2-cycle sout_valid gap, and sequence 00111100 11000011.
REQ-032 The bench SHALL cover: 8'hF0 with sout_ready toggling 1,0 -> 16 cycles of sout_valid, each bit held while ready=0, output 11110000.
REQ-033 The bench SHALL cover: MSB_FIRST=0 with 8'h01 -> sout 1,0,0,0,0,0,0,0.
REQ-034 The bench SHALL cover: reset_n pulled low after bit 3 of 8'hFF -> all outputs 0 within the same cycle; after release with fifo_empty=1, there is no read_en and busy=0.
REQ-035 The bench SHALL cover: enable dropped during bit 4 with a second word queued -> the current word completes and no further read_en occurs.
